// File: rtl/mb_rtu_tx.sv
// -----------------------------------------------------------------------------
// mb_rtu_tx -- Modbus RTU frame transmitter
//
// Takes a payload byte stream (valid/ready with a last flag), hands each byte
// to a uart_tx byte interface, appends the Modbus CRC16 (low byte first) and
// then holds the line silent for GAP_CYCLES clocks before the next frame.
//
// Build option:
//   MB_TX_CRC_EN  defined   -> CRC16 (poly 0xA001 reflected, init 0xFFFF) is
//                              computed on the fly and appended to each frame.
//                 undefined -> no CRC logic; the caller places the CRC bytes
//                              in the payload and MAX_LEN counts them.
//
// Parameters:
//   GAP_CYCLES  inter-frame silence in clk cycles (must be >= 2)
//   MAX_LEN     max payload bytes per frame; longer frames are truncated,
//               flagged on len_err, and the excess is drained up to s_last
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   s_data       payload byte
//   s_valid      s_data valid
//   s_last       s_data is the last payload byte of the frame
//   s_ready      byte accepted this cycle when s_valid is also high
//   tx_byte      byte for uart_tx, stable from tx_start until tx_done
//   tx_start     1-cycle pulse: uart_tx starts sending tx_byte
//   tx_done      1-cycle pulse from uart_tx: byte fully shifted out
//   busy         frame in progress or gap running
//   frame_done   1-cycle pulse when the post-frame gap expires
//   len_err      1-cycle pulse when a frame is truncated at MAX_LEN
// -----------------------------------------------------------------------------
module mb_rtu_tx #(
    parameter int GAP_CYCLES = 200000,
    parameter int MAX_LEN    = 254
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done,
    output logic       len_err
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // S_DROP drains the tail of a truncated frame up to s_last.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SEND,
        S_CRC_LO,
        S_CRC_HI,
        S_DROP,
        S_GAP
    } state_t;

    state_t           state;
    logic             last_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic accept;
    logic tx_ack;

    assign accept = s_valid & s_ready;
    // A tx_done coinciding with our own tx_start belongs to nothing we sent.
    assign tx_ack = tx_done & ~tx_start;

`ifdef MB_TX_CRC_EN
    logic [15:0] crc;
    logic        drop_q;

    // One full byte of the reflected Modbus CRC per clock.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            s_ready    <= 1'b0;
            tx_byte    <= 8'h00;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            last_q     <= 1'b0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
`ifdef MB_TX_CRC_EN
            crc        <= 16'hFFFF;
            drop_q     <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the
            // cycle that needs them, which keeps them exactly one cycle wide.
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;

            case (state)
                S_IDLE: begin
                    gap_cnt <= '0;
`ifdef MB_TX_CRC_EN
                    drop_q  <= 1'b0;
`endif
                    if (accept) begin
                        tx_byte  <= s_data;
                        last_q   <= s_last;
                        byte_cnt <= CNT_W'(1);
                        tx_start <= 1'b1;
                        s_ready  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SEND;
`ifdef MB_TX_CRC_EN
                        crc      <= crc16_byte(16'hFFFF, s_data);
`endif
                    end else begin
                        s_ready  <= 1'b1;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
`ifdef MB_TX_CRC_EN
                        crc      <= 16'hFFFF;
`endif
                    end
                end

                S_WAIT_BYTE: begin
                    if (accept) begin
                        tx_byte  <= s_data;
                        last_q   <= s_last;
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        tx_start <= 1'b1;
                        s_ready  <= 1'b0;
                        state    <= S_SEND;
`ifdef MB_TX_CRC_EN
                        crc      <= crc16_byte(crc, s_data);
`endif
                    end
                end

                S_SEND: begin
                    if (tx_ack) begin
                        if (last_q || byte_cnt == CNT_MAX) begin
                            // Reaching MAX_LEN without s_last truncates the frame.
                            if (!last_q) begin
                                len_err <= 1'b1;
                            end
`ifdef MB_TX_CRC_EN
                            drop_q   <= ~last_q;
                            tx_byte  <= crc[7:0];
                            tx_start <= 1'b1;
                            state    <= S_CRC_LO;
`else
                            if (last_q) begin
                                gap_cnt <= GAP_W'(1);
                                state   <= S_GAP;
                            end else begin
                                s_ready <= 1'b1;
                                state   <= S_DROP;
                            end
`endif
                        end else begin
                            s_ready <= 1'b1;
                            state   <= S_WAIT_BYTE;
                        end
                    end
                end

`ifdef MB_TX_CRC_EN
                S_CRC_LO: begin
                    if (tx_ack) begin
                        tx_byte  <= crc[15:8];
                        tx_start <= 1'b1;
                        state    <= S_CRC_HI;
                    end
                end

                S_CRC_HI: begin
                    if (tx_ack) begin
                        if (drop_q) begin
                            s_ready <= 1'b1;
                            state   <= S_DROP;
                        end else begin
                            gap_cnt <= GAP_W'(1);
                            state   <= S_GAP;
                        end
                    end
                end
`endif

                S_DROP: begin
                    // Excess bytes are swallowed; the gap starts after s_last.
                    if (accept && s_last) begin
                        s_ready <= 1'b0;
                        gap_cnt <= GAP_W'(1);
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    // Compare against GAP_CYCLES-1 because frame_done is
                    // registered and lands in the cycle gap_cnt reads GAP_CYCLES.
                    if (gap_cnt == GAP_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        s_ready    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_rtu_tx.sv
// -----------------------------------------------------------------------------
// tb_mb_rtu_tx -- self-checking bench for mb_rtu_tx
//
// A uart_tx model answers every tx_start with tx_done after UART_CYC cycles and
// pops the expected byte from a scoreboard queue; the stimulus pushes expected
// bytes (payload plus reference CRC when MB_TX_CRC_EN is defined) as frames
// are offered. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mb_rtu_tx;

    localparam int GAP_CYCLES = 20;
    localparam int MAX_LEN    = 8;
    localparam int UART_CYC   = 5;
    localparam int BUDGET     = 400;
`ifdef MB_TX_CRC_EN
    localparam int CRC_BYTES  = 2;
`else
    localparam int CRC_BYTES  = 0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic [7:0] s_data      = 8'h00;
    logic       s_valid     = 1'b0;
    logic       s_last      = 1'b0;
    logic       tx_done_m   = 1'b0;
    logic       tx_done_inj = 1'b0;
    logic       tx_done;
    logic       s_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       busy;
    logic       frame_done;
    logic       len_err;

    assign tx_done = tx_done_m | tx_done_inj;

    mb_rtu_tx #(
        .GAP_CYCLES(GAP_CYCLES),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_done(frame_done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks      = 0;
    int         n_pass        = 0;
    logic [7:0] exp_q[$];
    int         tx_start_cnt  = 0;
    int         done_cyc[64];
    int         last_done_cyc = 0;
    int         hold_err      = 0;
    int         overlap_err   = 0;
    int         len_err_cnt   = 0;
    int         len_err_cyc   = 0;
    int         acc_cyc       = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Bitwise reference CRC over the first n bytes of f.
    function automatic logic [15:0] ref_crc(input byte_q_t f, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, f[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    // uart_tx model: checks each byte against the scoreboard, verifies tx_byte
    // is held and no new tx_start arrives while busy, then pulses tx_done.
    always begin : uart_model
        logic [7:0] held;
        bit         aborted;
        @(negedge clk);
        tx_done_m = 1'b0;
        if (tx_start === 1'b1) begin
            tx_start_cnt++;
            check("tx_byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("tx_byte", tx_byte, exp_q.pop_front());
            held    = tx_byte;
            aborted = 1'b0;
            repeat (UART_CYC) begin
                @(negedge clk);
                if (rst_n !== 1'b1) aborted = 1'b1;
                if (!aborted && tx_byte !== held) hold_err++;
                if (!aborted && tx_start === 1'b1) overlap_err++;
            end
            done_cyc[(tx_start_cnt - 1) & 63] = cyc;
            last_done_cyc = cyc;
            tx_done_m = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (len_err === 1'b1) begin
            len_err_cnt++;
            len_err_cyc = cyc;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // NOTE: bench inputs are driven with blocking assignments on the falling
    // edge, so they are settled well before the DUT samples them.
    task automatic send_byte(input logic [7:0] d, input logic last,
                             input bit expect_start, input bit inj);
        int budget;
        @(negedge clk);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        budget  = 0;
        while (s_ready !== 1'b1 && budget < BUDGET) begin
            @(negedge clk);
            budget++;
        end
        check("s_ready_timeout", budget < BUDGET, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (expect_start) check("start_latency", tx_start, 1'b1);
        if (inj) begin
            // tx_done in the same cycle as tx_start must be ignored.
            tx_done_inj = 1'b1;
            @(negedge clk);
            tx_done_inj = 1'b0;
        end
    endtask

    task automatic send_frame(input byte_q_t f, input int inj_idx);
        int n;
        n = (f.size() < MAX_LEN) ? f.size() : MAX_LEN;
        for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
`ifdef MB_TX_CRC_EN
        begin
            logic [15:0] c;
            c = ref_crc(f, n);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
`endif
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == f.size() - 1, i < MAX_LEN, i == inj_idx);
        end
    endtask

    task automatic wait_frame_done(input string tag, output int fd_cyc);
        int budget;
        budget = 0;
        while (frame_done !== 1'b1 && budget < BUDGET) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_timeout"}, budget < BUDGET, 1'b1);
        fd_cyc = cyc;
    endtask

    initial begin : stimulus
        int      fd;
        int      base;
        int      lbase;
        int      early;
        int      budget;
        byte_q_t fa;
        byte_q_t fb;
        byte_q_t fc;
        byte_q_t ft;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready",    s_ready,    1'b0);
        check("rst_tx_byte",    tx_byte,    8'h00);
        check("rst_tx_start",   tx_start,   1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_len_err",    len_err,    1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1'b1);
        check("idle_busy",    busy,    1'b0);

        // Frame A: read holding register request
        fa = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
`ifndef MB_TX_CRC_EN
        fa.push_back(8'h84);
        fa.push_back(8'h0A);
`endif
        base = tx_start_cnt;
        send_frame(fa, -1);
        check("busy_in_frame", busy, 1'b1);
        wait_frame_done("frame_a", fd);
        check("gap_a",      fd - last_done_cyc, GAP_CYCLES);
        check("starts_a",   tx_start_cnt - base, 8);
        check("sb_empty_a", exp_q.size(), 0);
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 1'b0);
        check("busy_after_gap",       busy,       1'b0);
        check("ready_after_gap",      s_ready,    1'b1);

        // Stray tx_done while idle
        tx_done_inj = 1'b1;
        @(negedge clk);
        tx_done_inj = 1'b0;
        @(negedge clk);
        check("idle_tx_done_start", tx_start, 1'b0);
        check("idle_tx_done_busy",  busy,     1'b0);
        check("idle_tx_done_ready", s_ready,  1'b1);

        // Frame B (write single register), tx_done injected with a tx_start
        fb = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
`ifndef MB_TX_CRC_EN
        fb.push_back(8'h98);
        fb.push_back(8'h0B);
`endif
        base = tx_start_cnt;
        send_frame(fb, 2);

        // Frame C (single 0xFF, CRC works out to 0x00FF) offered during B's gap
        fc = '{8'hFF};
        exp_q.push_back(8'hFF);
`ifdef MB_TX_CRC_EN
        begin
            logic [15:0] c;
            c = ref_crc(fc, 1);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
`endif
        s_data  = 8'hFF;
        s_last  = 1'b1;
        s_valid = 1'b1;
        early   = 0;
        budget  = 0;
        while (frame_done !== 1'b1 && budget < BUDGET) begin
            if (s_ready === 1'b1) early++;
            @(negedge clk);
            budget++;
        end
        check("frame_b_timeout",     budget < BUDGET, 1'b1);
        check("gap_blocks_input",    early, 0);
        check("gap_b",               cyc - last_done_cyc, GAP_CYCLES);
        check("starts_b",            tx_start_cnt - base, 8);
        check("ready_at_frame_done", s_ready, 1'b1);
        base = tx_start_cnt;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("c_start_latency", tx_start, 1'b1);
        wait_frame_done("frame_c", fd);
        check("gap_c",    fd - last_done_cyc, GAP_CYCLES);
        check("starts_c", tx_start_cnt - base, 1 + CRC_BYTES);

        // Oversized frame: MAX_LEN+3 bytes, last on the final one
        for (int i = 0; i < MAX_LEN + 3; i++) ft.push_back(8'(i * 17 + 5));
        base  = tx_start_cnt;
        lbase = len_err_cnt;
        send_frame(ft, -1);
        wait_frame_done("trunc", fd);
        check("gap_trunc",      fd - acc_cyc, GAP_CYCLES);
        check("len_err_pulses", len_err_cnt - lbase, 1);
        check("len_err_timing", len_err_cyc - done_cyc[(base + MAX_LEN - 1) & 63], 1);
        check("starts_trunc",   tx_start_cnt - base, MAX_LEN + CRC_BYTES);
        check("sb_empty_trunc", exp_q.size(), 0);

        // Reset after the third tx_start of a frame
        base = tx_start_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back(fa[i]);
        for (int i = 0; i < 3; i++) send_byte(fa[i], 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_start", tx_start, 1'b0);
        check("mid_rst_tx_byte",  tx_byte,  8'h00);
        check("mid_rst_busy",     busy,     1'b0);
        check("mid_rst_s_ready",  s_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("starts_before_reset", tx_start_cnt - base, 3);
        repeat (UART_CYC + 4) @(negedge clk);
        check("sb_empty_reset",  exp_q.size(), 0);
        check("ready_after_rst", s_ready, 1'b1);
        base = tx_start_cnt;
        send_frame(fa, -1);
        wait_frame_done("after_reset", fd);
        check("gap_after_reset",    fd - last_done_cyc, GAP_CYCLES);
        check("starts_after_reset", tx_start_cnt - base, 8);
        check("sb_empty_final",     exp_q.size(), 0);

        // Whole-run invariants
        check("tx_byte_hold",     hold_err,    0);
        check("tx_start_overlap", overlap_err, 0);
        check("len_err_total",    len_err_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
